// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Holds decode-stage control and data for one cycle; a dependent instruction behind a load is held for exactly one bubble.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              id_reg_dst,
    input  logic              id_branch,
    input  logic              id_mem_read,
    input  logic              id_mem_to_reg,
    input  logic              id_mem_write,
    input  logic              id_alu_src,
    input  logic              id_reg_write,
    input  logic [1:0]        id_alu_op,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rd1,
    input  logic [DATA_W-1:0] id_rd2,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [5:0]        id_funct,
    input  logic [REG_W-1:0]  id_rs,
    input  logic [REG_W-1:0]  id_rt,
    input  logic [REG_W-1:0]  id_rd,

    input  logic              flush,

    output logic              ex_reg_dst,
    output logic              ex_branch,
    output logic              ex_mem_read,
    output logic              ex_mem_to_reg,
    output logic              ex_mem_write,
    output logic              ex_alu_src,
    output logic              ex_reg_write,
    output logic [1:0]        ex_alu_op,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_rd1,
    output logic [DATA_W-1:0] ex_rd2,
    output logic [DATA_W-1:0] ex_imm,
    output logic [5:0]        ex_funct,
    output logic [REG_W-1:0]  ex_rs,
    output logic [REG_W-1:0]  ex_rt,
    output logic [REG_W-1:0]  ex_rd,

    output logic              stall_out,
    output logic [15:0]       stall_count
);

    // state  | meaning
    // RUN    | normal advance, hazard detection active
    // BUBBLE | a load-use bubble was just inserted; EX holds no load, so no re-stall
    typedef enum logic {
        S_RUN    = 1'b0,
        S_BUBBLE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic              r_reg_dst;
    logic              r_branch;
    logic              r_mem_read;
    logic              r_mem_to_reg;
    logic              r_mem_write;
    logic              r_alu_src;
    logic              r_reg_write;
    logic [1:0]        r_alu_op;
    logic              r_valid;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [5:0]        r_funct;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [15:0]       r_stall_count;

    logic              w_load_use;
    logic              w_stall;
    logic              w_bubble;
    logic [15:0]       w_stall_count_nxt;

    assign w_load_use = r_valid & r_mem_read & (r_rt != '0) & id_valid &
                        ((r_rt == id_rs) | (r_rt == id_rt));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:    if (w_load_use && !flush) w_state_nxt = S_BUBBLE;
            S_BUBBLE: w_state_nxt = S_RUN;
            default:  w_state_nxt = S_RUN;
        endcase
    end

    // Flush outranks the hazard: it bubbles without stalling the front end.
    always_comb begin
        w_stall  = 1'b0;
        w_bubble = 1'b0;
        if (flush) begin
            w_bubble = 1'b1;
        end else if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_op     <= 2'b00;
            r_valid      <= 1'b0;
        end else if (w_bubble) begin
            r_reg_dst    <= 1'b0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_mem_write  <= 1'b0;
            r_alu_src    <= 1'b0;
            r_reg_write  <= 1'b0;
            r_alu_op     <= 2'b00;
            r_valid      <= 1'b0;
        end else begin
            r_reg_dst    <= id_reg_dst;
            r_branch     <= id_branch;
            r_mem_read   <= id_mem_read;
            r_mem_to_reg <= id_mem_to_reg;
            r_mem_write  <= id_mem_write;
            r_alu_src    <= id_alu_src;
            r_reg_write  <= id_reg_write;
            r_alu_op     <= id_alu_op;
            r_valid      <= id_valid;
        end
    end

    // Operand and register-number fields keep their old values across a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd1   <= '0;
            r_rd2   <= '0;
            r_imm   <= '0;
            r_funct <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_rd    <= '0;
        end else if (!w_bubble) begin
            r_rd1   <= id_rd1;
            r_rd2   <= id_rd2;
            r_imm   <= id_imm;
            r_funct <= id_funct;
            r_rs    <= id_rs;
            r_rt    <= id_rt;
            r_rd    <= id_rd;
        end
    end

    assign w_stall_count_nxt = (w_stall && (r_stall_count != 16'hFFFF)) ?
                               r_stall_count + 16'd1 : r_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stall_count <= 16'd0;
        end else begin
            r_stall_count <= w_stall_count_nxt;
        end
    end

    assign ex_reg_dst    = r_reg_dst;
    assign ex_branch     = r_branch;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_to_reg = r_mem_to_reg;
    assign ex_mem_write  = r_mem_write;
    assign ex_alu_src    = r_alu_src;
    assign ex_reg_write  = r_reg_write;
    assign ex_alu_op     = r_alu_op;
    assign ex_valid      = r_valid;
    assign ex_rd1        = r_rd1;
    assign ex_rd2        = r_rd2;
    assign ex_imm        = r_imm;
    assign ex_funct      = r_funct;
    assign ex_rs         = r_rs;
    assign ex_rt         = r_rt;
    assign ex_rd         = r_rd;
    assign stall_out     = w_stall;
    assign stall_count   = r_stall_count;

endmodule
